reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//   Parametrised multi-port register file: next generation of the 32x32 2R/1W reg_file.
//   Configurable width, depth and read/write port count, with an optional hardwired zero
//   register, write-to-read bypass and a registered-read mode.
//   Serves as the architectural register file of the core pipeline (decode reads, writeback writes).
// PARAMETERS
//   DATA_W    32  bits per register
//   DEPTH     32  number of registers (need not be a power of two)
//   NUM_RD    2   read ports (1..4)
//   NUM_WR    1   write ports (1..2)
//   ZERO_REG  1   1: register 0 reads 0 and ignores writes
//   BYPASS    1   1: same-cycle write data forwarded to a matching read
//   SYNC_READ 0   0: combinational read; 1: read data registered, latency 1
//   AW (localparam) = clog2(DEPTH), minimum 1
// PORTS
//   clk_i     in   1            clock; all state updates on the rising edge
//   rst_ni    in   1            asynchronous reset, active low
//   we_i      in   NUM_WR       per-port write enable
//   waddr_i   in   NUM_WR*AW    write addresses, port k at [k*AW +: AW]
//   wdata_i   in   NUM_WR*DW    write data, port k at [k*DATA_W +: DATA_W]
//   raddr_i   in   NUM_RD*AW    read addresses, port j at [j*AW +: AW]
//   rdata_o   out  NUM_RD*DW    read data, port j at [j*DATA_W +: DATA_W]
// BEHAVIOUR
//   - Reset (rst_ni=0, async): all DEPTH registers cleared to 0; SYNC_READ output regs cleared to 0.
//     rdata_o reads 0 during reset in both modes. Reset asserted mid-write: the write is lost.
//   - Write: on posedge, we_i[k]=1 stores wdata_i[k] at waddr_i[k].
//     Writes to addr>=DEPTH are ignored. With ZERO_REG=1, writes to addr 0 are ignored.
//   - Write collision (NUM_WR=2, both enabled, same address): port 1 wins; port 0 data discarded.
//   - Read, SYNC_READ=0: rdata_o[j] = reg[raddr_i[j]] combinationally.
//     With BYPASS=1, if any enabled write matches raddr_i[j] in the same cycle, that wdata is
//     returned instead; collision priority applies (port 1 over port 0).
//     With BYPASS=0, the old value is returned; the new value is visible the cycle after the edge.
//   - Read, SYNC_READ=1: rdata_o[j] is registered at posedge from the same selection
//     (array + bypass); read latency is 1 cycle.
//     With BYPASS=0, the register captures the pre-write value (read-before-write).
//   - Read override: raddr >= DEPTH returns 0. With ZERO_REG=1, addr 0 returns 0 even when bypass
//     would match. Both rules apply in both read modes.
//   - All read ports are independent; several ports may read the same address in the same cycle.
//   - No X propagation: unwritten registers read 0 after reset.
// STRUCTURE
//   rf_pkg: clog2 function, default-parameter constants, RF_MAX_RD/RF_MAX_WR limits.
//   rf_read_port sub-module, generate-instantiated NUM_RD times. Each instance contains:
//     array mux, bypass compare against all write ports, zero/range override, optional output reg.
//   Top level holds the storage array, the write decode and the collision priority.
// TESTING
//   1. Reset: write 5<-7, then pulse rst_ni low for 3ns between edges -> all ports read 0 immediately;
//      reg 5 reads 0 after release.
//   2. Basic: write reg5=0x7, reg6=0xA5A5A5A5; next cycle read r0=5, r1=6 -> 0x7, 0xA5A5A5A5.
//   3. Zero reg: write reg0<-3 (ZERO_REG=1) -> reg0 reads 0.
//      With ZERO_REG=0 the same write -> reads 3.
//   4. Bypass: same cycle we=1, waddr=9, wdata=0x55, raddr=9.
//      BYPASS=1 -> 0x55 before the edge. BYPASS=0 -> old value 0, then 0x55 after the edge.
//   5. Collision (NUM_WR=2): both ports write addr 12, data 0x11 / 0x22 -> reg12 = 0x22;
//      bypass also returns 0x22.
//   6. SYNC_READ=1, DEPTH=24: raddr=3 holding 0x3C -> rdata 0x3C exactly one cycle later;
//      raddr=30 -> 0; write to 30 -> no register changes.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised multi-port register file.
// The storage top and the read-port slices both import this package.
package rf_pkg;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_DEPTH  = 32;
  localparam int RF_DEF_NUM_RD = 2;
  localparam int RF_DEF_NUM_WR = 1;
  localparam int RF_MAX_RD     = 4;
  localparam int RF_MAX_WR     = 2;

  // Address width for a given depth; a single-entry file still needs one address bit.
  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port of the register file: array mux, write bypass, zero/range override
// and an optional output register.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DEF_DATA_W,
  parameter int DEPTH     = RF_DEF_DEPTH,
  parameter int AW        = rf_clog2(RF_DEF_DEPTH),
  parameter int NUM_WR    = RF_DEF_NUM_WR,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AW-1:0]            raddr_i,
  input  logic [DATA_W-1:0]        mem_i [DEPTH],
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] sel;
  logic              in_range;

  assign in_range = int'(raddr_i) < DEPTH;

  always_comb begin
    sel = '0;
    if (in_range) sel = mem_i[raddr_i];
    // Ascending scan so the higher write port wins a collision, matching the array.
    if (BYPASS != 0) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && (waddr_i[k*AW +: AW] == raddr_i)) sel = wdata_i[k*DATA_W +: DATA_W];
      end
    end
    if (!in_range || ((ZERO_REG != 0) && (raddr_i == '0))) sel = '0;
  end

  if (SYNC_READ != 0) begin : g_sync
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= sel;
    end
    assign rdata_o = rdata_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk_i;
    // Bypass data could otherwise leak through while the array is held in reset.
    assign rdata_o = rst_ni ? sel : '0;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file: storage array, filtered write decode with
// port-1-over-port-0 collision priority, and NUM_RD independent read ports.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DEF_DATA_W,
  parameter int DEPTH     = RF_DEF_DEPTH,
  parameter int NUM_RD    = RF_DEF_NUM_RD,
  parameter int NUM_WR    = RF_DEF_NUM_WR,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0,
  localparam int AW       = rf_clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] wr_en;

  // Drop writes that target a non-existent register or the hardwired zero register.
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_en[k] = we_i[k]
               && (int'(waddr_i[k*AW +: AW]) < DEPTH)
               && !((ZERO_REG != 0) && (waddr_i[k*AW +: AW] == '0));
    end
  end

  // Later loop iterations override earlier ones, so port 1 wins a same-address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k]) mem[waddr_i[k*AW +: AW]] <= wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    rf_read_port #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AW        (AW),
      .NUM_WR    (NUM_WR),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS),
      .SYNC_READ (SYNC_READ)
    ) u_rd (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raddr_i (raddr_i[j*AW +: AW]),
      .mem_i   (mem),
      .wr_en_i (wr_en),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations (2W bypass/zero-reg, 1W no-bypass/no-zero,
// 1W registered read with DEPTH=24) checked against a scoreboard queue.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut_a: NUM_WR=2, ZERO_REG=1, BYPASS=1, combinational read
  logic [1:0]  a_we;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  // dut_b: NUM_WR=1, ZERO_REG=0, BYPASS=0, combinational read
  logic        b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  // dut_c: NUM_WR=1, DEPTH=24, ZERO_REG=1, BYPASS=1, registered read
  logic        c_we;
  logic [4:0]  c_waddr;
  logic [31:0] c_wdata;
  logic [9:0]  c_raddr;
  logic [63:0] c_rdata;

  reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .we_i(a_we), .waddr_i(a_waddr), .wdata_i(a_wdata),
    .raddr_i(a_raddr), .rdata_o(a_rdata));

  reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0), .SYNC_READ(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .raddr_i(b_raddr), .rdata_o(b_rdata));

  reg_file_mp #(.DATA_W(32), .DEPTH(24), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .we_i(c_we), .waddr_i(c_waddr), .wdata_i(c_wdata),
    .raddr_i(c_raddr), .rdata_o(c_rdata));

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int n_cmp = 0;
  int n_err = 0;

  // Port index: 0/1 = dut_a, 2/3 = dut_b, 4/5 = dut_c
  function automatic logic [31:0] port_val(input int j);
    case (j)
      0: return a_rdata[31:0];
      1: return a_rdata[63:32];
      2: return b_rdata[31:0];
      3: return b_rdata[63:32];
      4: return c_rdata[31:0];
      5: return c_rdata[63:32];
      default: return '0;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    a_raddr = {5'd31, 5'd7};
    b_raddr = {5'd0, 5'd17};
    c_raddr = {5'd23, 5'd0};
    for (int j = 0; j < 6; j++) exp_q.push_back(32'd0);
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL reset_init port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    a_we = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'd0, 32'd7};
    @(negedge clk);
    a_we = 2'b00; a_raddr = {5'd5, 5'd5};
    exp_q.push_back(32'd7);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (a_rdata[31:0] !== exp) begin
      n_err++;
      $display("FAIL pre_reset_reg5: got %h expected %h", a_rdata[31:0], exp);
    end
    // Write in flight plus a 3ns reset pulse between edges
    a_we = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'd0, 32'd9};
    rst_n = 1'b0;
    for (int j = 0; j < 6; j++) exp_q.push_back(32'd0);
    #1;
    for (int j = 0; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL in_reset port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    #2;
    a_we = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int j = 0; j < 2; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL after_reset_reg5 port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    a_we = 2'b11; a_waddr = {5'd6, 5'd5}; a_wdata = {32'hA5A5A5A5, 32'h7};
    b_we = 1'b1; b_waddr = 5'd5; b_wdata = 32'h7;
    c_we = 1'b1; c_waddr = 5'd5; c_wdata = 32'h7;
    @(negedge clk);
    a_we = 2'b00;
    b_waddr = 5'd6; b_wdata = 32'hA5A5A5A5;
    c_waddr = 5'd6; c_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    b_we = 1'b0; c_we = 1'b0;
    a_raddr = {5'd6, 5'd5}; b_raddr = {5'd6, 5'd5}; c_raddr = {5'd6, 5'd5};
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(32'h7); exp_q.push_back(32'hA5A5A5A5);
    end
    #2;
    for (int j = 0; j < 4; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL basic port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    @(negedge clk);
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL basic_sync port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    a_we = 2'b01; a_waddr = {5'd0, 5'd0}; a_wdata = {32'd0, 32'd3}; a_raddr = {5'd0, 5'd0};
    b_we = 1'b1; b_waddr = 5'd0; b_wdata = 32'd3; b_raddr = {5'd0, 5'd0};
    exp_q.push_back(32'd0);
    #2;
    exp = exp_q.pop_front();
    n_cmp++;
    if (a_rdata[31:0] !== exp) begin
      n_err++;
      $display("FAIL zero_bypass_a: got %h expected %h", a_rdata[31:0], exp);
    end
    @(negedge clk);
    a_we = 2'b00; b_we = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd3); exp_q.push_back(32'd3);
    #2;
    for (int j = 0; j < 4; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL zero_reg port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a_we = 2'b01; a_waddr = {5'd0, 5'd9}; a_wdata = {32'd0, 32'h55}; a_raddr = {5'd9, 5'd9};
    b_we = 1'b1; b_waddr = 5'd9; b_wdata = 32'h55; b_raddr = {5'd9, 5'd9};
    exp_q.push_back(32'h55); exp_q.push_back(32'h55);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h0);
    #2;
    for (int j = 0; j < 4; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL bypass_same_cycle port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    @(negedge clk);
    a_we = 2'b00; b_we = 1'b0;
    exp_q.push_back(32'h55); exp_q.push_back(32'h55);
    #2;
    for (int j = 2; j < 4; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL bypass_after_edge port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    a_we = 2'b11; a_waddr = {5'd12, 5'd12}; a_wdata = {32'h22, 32'h11}; a_raddr = {5'd12, 5'd12};
    exp_q.push_back(32'h22); exp_q.push_back(32'h22);
    #2;
    for (int j = 0; j < 2; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL collision_bypass port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    @(negedge clk);
    a_we = 2'b00;
    exp_q.push_back(32'h22);
    #2;
    exp = exp_q.pop_front();
    n_cmp++;
    if (a_rdata[31:0] !== exp) begin
      n_err++;
      $display("FAIL collision_stored: got %h expected %h", a_rdata[31:0], exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wa;
    logic [31:0] prev_d;
    prev_d = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wa = 5'(16 + i);
      b_we = 1'b1; b_waddr = wa; b_wdata = 32'(i * 32'h1111 + 1);
      b_raddr = {wa, 5'(wa - 5'd1)};
      exp_q.push_back(prev_d);
      exp_q.push_back(32'd0);
      prev_d = b_wdata;
      #2;
      for (int j = 2; j < 4; j++) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (port_val(j) !== exp) begin
          n_err++;
          $display("FAIL back_to_back[%0d] port%0d: got %h expected %h", i, j, port_val(j), exp);
        end
      end
    end
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic test_sync_read();
    @(negedge clk);
    c_we = 1'b1; c_waddr = 5'd3; c_wdata = 32'h3C; c_raddr = {5'd5, 5'd5};
    @(negedge clk);
    c_we = 1'b0; c_raddr = {5'd3, 5'd3};
    exp_q.push_back(32'h7); exp_q.push_back(32'h7);
    #2;
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_latency port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    @(negedge clk);
    exp_q.push_back(32'h3C); exp_q.push_back(32'h3C);
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_data port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    c_raddr = {5'd3, 5'd30};
    exp_q.push_back(32'h0); exp_q.push_back(32'h3C);
    @(negedge clk);
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_range port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    c_we = 1'b1; c_waddr = 5'd30; c_wdata = 32'hDEADBEEF; c_raddr = {5'd30, 5'd30};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    c_we = 1'b0;
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_range_write port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    // Out-of-range write must not alias onto any real register
    c_raddr = {5'd6, 5'd5};
    exp_q.push_back(32'h7); exp_q.push_back(32'hA5A5A5A5);
    @(negedge clk);
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_no_alias port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
    c_raddr = {5'd22, 5'd14};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    for (int j = 4; j < 6; j++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (port_val(j) !== exp) begin
        n_err++;
        $display("FAIL sync_untouched port%0d: got %h expected %h", j, port_val(j), exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] model [32];
    logic [1:0]  we;
    logic [4:0]  w0, w1, ra;
    logic [31:0] d0, d1, e;
    logic [4:0]  r [2];
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      we = 2'($urandom_range(0, 3));
      w0 = 5'($urandom_range(0, 31));
      w1 = ($urandom_range(0, 3) == 0) ? w0 : 5'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      r[0] = ($urandom_range(0, 2) == 0) ? w0 : 5'($urandom_range(0, 31));
      r[1] = ($urandom_range(0, 2) == 0) ? w1 : 5'($urandom_range(0, 31));
      a_we = we; a_waddr = {w1, w0}; a_wdata = {d1, d0}; a_raddr = {r[1], r[0]};
      for (int j = 0; j < 2; j++) begin
        ra = r[j];
        e = model[ra];
        if (we[0] && (w0 == ra)) e = d0;
        if (we[1] && (w1 == ra)) e = d1;
        if (ra == 5'd0) e = 32'd0;
        exp_q.push_back(e);
      end
      #2;
      for (int j = 0; j < 2; j++) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (port_val(j) !== exp) begin
          n_err++;
          $display("FAIL random[%0d] port%0d: got %h expected %h", it, j, port_val(j), exp);
        end
      end
      if (we[0] && (w0 != 5'd0)) model[w0] = d0;
      if (we[1] && (w1 != 5'd0)) model[w1] = d1;
    end
    @(negedge clk);
    a_we = 2'b00;
  endtask

  initial begin
    a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    c_we = '0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_collision();
    test_back_to_back();
    test_sync_read();
    test_random();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
